// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Shared opcode, instruction-class, state and ALU constants for the
//           load/store control sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam logic [4:0] C_ALU_ADD  = 5'b00011;

    localparam logic [4:0] C_OPC_LD   = 5'b00000;
    localparam logic [4:0] C_OPC_LDI  = 5'b00001;
    localparam logic [4:0] C_OPC_ST   = 5'b00010;

    typedef enum logic [1:0] {
        CLS_LD  = 2'd0,
        CLS_LDI = 2'd1,
        CLS_ST  = 2'd2,
        CLS_ILL = 2'd3
    } opc_cls_t;

    typedef logic [3:0] state_t;

    localparam state_t C_ST_IDLE = 4'd0;
    localparam state_t C_ST_T0   = 4'd1;
    localparam state_t C_ST_T1   = 4'd2;
    localparam state_t C_ST_T2   = 4'd3;
    localparam state_t C_ST_T3   = 4'd4;
    localparam state_t C_ST_T4   = 4'd5;
    localparam state_t C_ST_T5   = 4'd6;
    localparam state_t C_ST_T6   = 4'd7;
    localparam state_t C_ST_T7   = 4'd8;
    localparam state_t C_ST_DONE = 4'd9;
    localparam state_t C_ST_ILL  = 4'd10;

endpackage

`default_nettype wire

// File: rtl/ctrl_opc_decode.sv
// ============================================================================
// Module  : ctrl_opc_decode
// Brief   : Classifies the instruction opcode field as ld / ldi / st / illegal.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_opc_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opc,
    output opc_cls_t         o_cls
);

    always_comb begin
        if (i_opc == OPC_W'(C_OPC_LD)) begin
            o_cls = CLS_LD;
        end else if (i_opc == OPC_W'(C_OPC_LDI)) begin
            o_cls = CLS_LDI;
        end else if (i_opc == OPC_W'(C_OPC_ST)) begin
            o_cls = CLS_ST;
        end else begin
            o_cls = CLS_ILL;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl_seq.sv
// ============================================================================
// Module  : mem_ctrl_seq
// Brief   : Moore control sequencer for fetch plus ld/ldi/st execution.
//           Define MEM_CTRL_MEM_WAIT_EN to stall memory states on mem_ready.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] ALU_ADD = C_ALU_ADD,
    parameter int          OPC_W  = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        PCin,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Grb,
    output logic        Gra,
    output logic        BAout,
    output logic        Cout,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t   r_state;
    state_t   w_next;
    opc_cls_t r_cls;
    opc_cls_t w_cls;
    logic     w_mem_ok;
    logic     w_unused;

    assign w_unused = ^{ir[31-OPC_W:0], mem_ready};

`ifdef MEM_CTRL_MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    ctrl_opc_decode #(
        .OPC_W (OPC_W)
    ) u_opc_decode (
        .i_opc (ir[31 -: OPC_W]),
        .o_cls (w_cls)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_ST_IDLE: if (start) w_next = C_ST_T0;
            C_ST_T0:   w_next = C_ST_T1;
            C_ST_T1:   if (w_mem_ok) w_next = C_ST_T2;
            C_ST_T2:   w_next = (w_cls == CLS_ILL) ? C_ST_ILL : C_ST_T3;
            C_ST_T3:   w_next = C_ST_T4;
            C_ST_T4:   w_next = C_ST_T5;
            C_ST_T5:   w_next = (r_cls == CLS_LDI) ? C_ST_DONE : C_ST_T6;
            C_ST_T6:   if (r_cls != CLS_LD || w_mem_ok) w_next = C_ST_T7;
            C_ST_T7:   if (r_cls != CLS_ST || w_mem_ok) w_next = C_ST_DONE;
            C_ST_DONE: w_next = C_ST_IDLE;
            C_ST_ILL:  w_next = C_ST_IDLE;
            default:   w_next = C_ST_IDLE;
        endcase
    end

    // Instruction class is captured alongside the state so T5..T7 remain Moore.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= C_ST_IDLE;
            r_cls   <= CLS_LD;
        end else begin
            r_state <= w_next;
            if (r_state == C_ST_T2) begin
                r_cls <= w_cls;
            end
        end
    end

    always_comb begin
        PCout   = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        ZLowOut = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Grb     = 1'b0;
        Gra     = 1'b0;
        BAout   = 1'b0;
        Cout    = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        alu_op  = 5'b00000;
        done    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            C_ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            C_ST_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            C_ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            C_ST_T3: begin
                Grb   = 1'b1;
                BAout = 1'b1;
                Yin   = 1'b1;
            end
            C_ST_T4: begin
                Cout   = 1'b1;
                Zin    = 1'b1;
                alu_op = ALU_ADD;
            end
            C_ST_T5: begin
                ZLowOut = 1'b1;
                if (r_cls == CLS_LDI) begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            C_ST_T6: begin
                MDRin = 1'b1;
                if (r_cls == CLS_ST) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            C_ST_T7: begin
                if (r_cls == CLS_ST) begin
                    Write = 1'b1;
                end else begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end
            end
            C_ST_DONE: done    = 1'b1;
            C_ST_ILL:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign busy = (r_state != C_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl_seq.sv
// ============================================================================
// Module  : tb_mem_ctrl_seq
// Brief   : Vector-table bench for mem_ctrl_seq plus multi-cycle sequences.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;
    logic PCout, IncPC, MARin, Zin, ZLowOut, PCin, Read, Write, MDRin, MDRout;
    logic IRin, Yin, Grb, Gra, BAout, Cout, Rin, Rout, busy, done, illegal;
    logic [4:0] alu_op;

    mem_ctrl_seq u_dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin),
        .ZLowOut(ZLowOut), .PCin(PCin), .Read(Read), .Write(Write),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Grb(Grb),
        .Gra(Gra), .BAout(BAout), .Cout(Cout), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [25:0] w_obs;
    assign w_obs = {PCout, IncPC, MARin, Zin, ZLowOut, PCin, Read, Write, MDRin,
                    MDRout, IRin, Yin, Grb, Gra, BAout, Cout, Rin, Rout,
                    alu_op, busy, done, illegal};

    localparam logic [25:0] M_PCOUT  = 26'd1 << 25;
    localparam logic [25:0] M_INCPC  = 26'd1 << 24;
    localparam logic [25:0] M_MARIN  = 26'd1 << 23;
    localparam logic [25:0] M_ZIN    = 26'd1 << 22;
    localparam logic [25:0] M_ZLOW   = 26'd1 << 21;
    localparam logic [25:0] M_PCIN   = 26'd1 << 20;
    localparam logic [25:0] M_READ   = 26'd1 << 19;
    localparam logic [25:0] M_WRITE  = 26'd1 << 18;
    localparam logic [25:0] M_MDRIN  = 26'd1 << 17;
    localparam logic [25:0] M_MDROUT = 26'd1 << 16;
    localparam logic [25:0] M_IRIN   = 26'd1 << 15;
    localparam logic [25:0] M_YIN    = 26'd1 << 14;
    localparam logic [25:0] M_GRB    = 26'd1 << 13;
    localparam logic [25:0] M_GRA    = 26'd1 << 12;
    localparam logic [25:0] M_BAOUT  = 26'd1 << 11;
    localparam logic [25:0] M_COUT   = 26'd1 << 10;
    localparam logic [25:0] M_RIN    = 26'd1 << 9;
    localparam logic [25:0] M_ROUT   = 26'd1 << 8;
    localparam logic [25:0] M_ADD    = 26'b00011 << 3;
    localparam logic [25:0] M_BUSY   = 26'd1 << 2;
    localparam logic [25:0] M_DONE   = 26'd1 << 1;
    localparam logic [25:0] M_ILLEG  = 26'd1;

    localparam logic [25:0] E_IDLE   = 26'd0;
    localparam logic [25:0] E_T0     = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY;
    localparam logic [25:0] E_T1     = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_BUSY;
    localparam logic [25:0] E_T2     = M_MDROUT | M_IRIN | M_BUSY;
    localparam logic [25:0] E_T3     = M_GRB | M_BAOUT | M_YIN | M_BUSY;
    localparam logic [25:0] E_T4     = M_COUT | M_ZIN | M_ADD | M_BUSY;
    localparam logic [25:0] E_T5_LDI = M_ZLOW | M_GRA | M_RIN | M_BUSY;
    localparam logic [25:0] E_T5_MEM = M_ZLOW | M_MARIN | M_BUSY;
    localparam logic [25:0] E_T6_LD  = M_READ | M_MDRIN | M_BUSY;
    localparam logic [25:0] E_T6_ST  = M_GRA | M_ROUT | M_MDRIN | M_BUSY;
    localparam logic [25:0] E_T7_LD  = M_MDROUT | M_GRA | M_RIN | M_BUSY;
    localparam logic [25:0] E_T7_ST  = M_WRITE | M_BUSY;
    localparam logic [25:0] E_DONE   = M_DONE | M_BUSY;
    localparam logic [25:0] E_ILL    = M_ILLEG | M_BUSY;

    localparam logic [31:0] IR_LDI = 32'h0880_0065;
    localparam logic [31:0] IR_LD  = 32'h0080_0010;
    localparam logic [31:0] IR_ST  = 32'h1080_0010;
    localparam logic [31:0] IR_BAD = 32'hF800_0000;
    localparam logic [31:0] IR_OP3 = 32'h1800_0000;

`ifdef MEM_CTRL_MEM_WAIT_EN
    localparam logic C_READY = 1'b1;
`else
    localparam logic C_READY = 1'b0;
`endif

    typedef struct {
        logic        clr;
        logic        start;
        logic [31:0] ir;
        logic [25:0] exp;
    } vec_t;

    vec_t vec[80];
    int   nvec = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic c, input logic s, input logic [31:0] i,
                       input logic [25:0] e);
        vec[nvec].clr   = c;
        vec[nvec].start = s;
        vec[nvec].ir    = i;
        vec[nvec].exp   = e;
        nvec++;
    endtask

    task automatic check(input string name, input logic [25:0] act,
                         input logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Read/Write exclusivity and single bus driver hold in every cycle.
    task automatic check_inv(input string name);
        checks++;
        if ((Read && Write) ||
            $countones({PCout, ZLowOut, MDRout, Rout, BAout, Cout}) > 1) begin
            failures++;
            $display("FAIL %s bus/rw conflict: obs %h required no conflict", name, w_obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cyc;

    initial begin
        clr = 1'b0; start = 1'b0; ir = 32'd0; mem_ready = C_READY;

        // reset two cycles; start during reset is ignored
        add(0, 0, IR_LDI, E_IDLE);
        add(0, 1, IR_LDI, E_IDLE);
        // ldi: T0..T5 then DONE on cycle 7
        add(1, 1, IR_LDI, E_T0);
        add(1, 0, IR_LDI, E_T1);
        add(1, 0, IR_LDI, E_T2);
        add(1, 0, IR_LDI, E_T3);
        add(1, 0, IR_LDI, E_T4);
        add(1, 0, IR_LDI, E_T5_LDI);
        add(1, 0, IR_LDI, E_DONE);
        add(1, 0, IR_LDI, E_IDLE);
        // ld, start held high while busy
        add(1, 1, IR_LD, E_T0);
        add(1, 1, IR_LD, E_T1);
        add(1, 1, IR_LD, E_T2);
        add(1, 1, IR_LD, E_T3);
        add(1, 1, IR_LD, E_T4);
        add(1, 1, IR_LD, E_T5_MEM);
        add(1, 1, IR_LD, E_T6_LD);
        add(1, 1, IR_LD, E_T7_LD);
        add(1, 0, IR_LD, E_DONE);
        add(1, 0, IR_LD, E_IDLE);
        // st
        add(1, 1, IR_ST, E_T0);
        add(1, 0, IR_ST, E_T1);
        add(1, 0, IR_ST, E_T2);
        add(1, 0, IR_ST, E_T3);
        add(1, 0, IR_ST, E_T4);
        add(1, 0, IR_ST, E_T5_MEM);
        add(1, 0, IR_ST, E_T6_ST);
        add(1, 0, IR_ST, E_T7_ST);
        add(1, 0, IR_ST, E_DONE);
        add(1, 0, IR_ST, E_IDLE);
        // illegal opcodes 11111 and 00011
        add(1, 1, IR_BAD, E_T0);
        add(1, 0, IR_BAD, E_T1);
        add(1, 0, IR_BAD, E_T2);
        add(1, 0, IR_BAD, E_ILL);
        add(1, 0, IR_BAD, E_IDLE);
        add(1, 1, IR_OP3, E_T0);
        add(1, 0, IR_OP3, E_T1);
        add(1, 0, IR_OP3, E_T2);
        add(1, 0, IR_OP3, E_ILL);
        add(1, 0, IR_OP3, E_IDLE);
        // reset during T4 of ld
        add(1, 1, IR_LD, E_T0);
        add(1, 0, IR_LD, E_T1);
        add(1, 0, IR_LD, E_T2);
        add(1, 0, IR_LD, E_T3);
        add(1, 0, IR_LD, E_T4);
        add(0, 0, IR_LD, E_IDLE);
        add(1, 0, IR_LD, E_IDLE);

        for (int i = 0; i < nvec; i++) begin
            clr   = vec[i].clr;
            start = vec[i].start;
            ir    = vec[i].ir;
            step();
            check($sformatf("vec%0d", i), w_obs, vec[i].exp);
            check_inv($sformatf("vec%0d", i));
        end

        // ld end-to-end latency measured up to the done pulse
        start = 1'b1; ir = IR_LD;
        step();
        cyc = 1;
        start = 1'b0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
        check("ld_latency", 26'(cyc), 26'd9);
        step();
        check("ld_after_done", w_obs, E_IDLE);

`ifdef MEM_CTRL_MEM_WAIT_EN
        // T1 stalls while mem_ready is low, then advances to T2
        mem_ready = 1'b0; start = 1'b1; ir = IR_LDI;
        step();
        check("wait_t0", w_obs, E_T0);
        start = 1'b0;
        step();
        check("wait_t1_c1", w_obs, E_T1);
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("wait_t1_c%0d", k), w_obs, E_T1);
        end
        mem_ready = 1'b1;
        step();
        check("wait_t2", w_obs, E_T2);
        for (int k = 0; k < 3; k++) step();
        check("wait_t5", w_obs, E_T5_LDI);
        step();
        check("wait_done", w_obs, E_DONE);
        step();
`else
        // mem_ready is ignored: a held-low mem_ready does not stall T1
        mem_ready = 1'b0; start = 1'b1; ir = IR_ST;
        step();
        start = 1'b0;
        step();
        check("nowait_t1", w_obs, E_T1);
        step();
        check("nowait_t2", w_obs, E_T2);
        for (int k = 0; k < 5; k++) step();
        check("nowait_t7", w_obs, E_T7_ST);
        step();
        check("nowait_done", w_obs, E_DONE);
        step();
`endif
        check("final_idle", w_obs, E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
